mc_ctrl: RTL

Multi-cycle main control unit for the MIPS core. It sequences every instruction through fetch, decode, execute, memory and write-back states. It drives the select inputs of the datapath muxes (register-destination, ALU-source, write-back-source) plus all write enables. It also inserts the external-interrupt entry sequence at instruction boundaries.

---
 rtl/mc_ctrl_if.sv | 46 ++++
 rtl/mc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the MIPS datapath.
// The controller drives the master side and the datapath the slave side.
interface mc_ctrl_if;
    // Instruction fields and status flags sampled by the controller
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic       zero;
    logic       hitdev;
    logic       intreq;
    logic       exl;

    // Write enables
    logic       pcwr;
    logic       irwr;
    logic       regwr;
    logic       memwr;
    logic       prwe;
    logic       cp0we;
    logic       epcwr;
    logic       exlset;
    logic       exlclr;

    // Datapath mux selects
    logic [1:0] regdst;
    logic       alusrc;
    logic       extop;
    logic [1:0] aluop;
    logic [2:0] memtoreg;
    logic [2:0] npcop;

    // Debug view of the sequencer state
    logic [2:0] state;

    modport master (
        input  op, funct, rs, zero, hitdev, intreq, exl,
        output pcwr, irwr, regwr, memwr, prwe, cp0we, epcwr, exlset, exlclr,
        output regdst, alusrc, extop, aluop, memtoreg, npcop, state
    );

    modport slave (
        output op, funct, rs, zero, hitdev, intreq, exl,
        input  pcwr, irwr, regwr, memwr, prwe, cp0we, epcwr, exlset, exlclr,
        input  regdst, alusrc, extop, aluop, memtoreg, npcop, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main control unit for the MIPS core.
// Sequences FETCH/DCD/EXE/MEM/WB, drives datapath selects and write enables,
// and inserts the interrupt entry state at instruction boundaries.
module mc_ctrl (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_INT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [4:0] RS_MFC0  = 5'b00000;
    localparam logic [4:0] RS_MTC0  = 5'b00100;
    localparam logic [4:0] RS_ERET  = 5'b10000;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_JMP  = 3'b010;
    localparam logic [2:0] NPC_JR   = 3'b011;
    localparam logic [2:0] NPC_EPC  = 3'b100;
    localparam logic [2:0] NPC_HDL  = 3'b101;

    localparam logic [2:0] M2R_ALU  = 3'b000;
    localparam logic [2:0] M2R_DMEM = 3'b001;
    localparam logic [2:0] M2R_PC4  = 3'b010;
    localparam logic [2:0] M2R_CP0  = 3'b011;
    localparam logic [2:0] M2R_PRRD = 3'b100;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_R31   = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_LUI  = 2'b11;

    state_t     r_state;
    state_t     w_next;
    state_t     w_end_next;

    // Instruction decode
    logic       w_rtype, w_cop0;
    logic       w_addu, w_subu, w_jr, w_jalr;
    logic       w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic       w_mfc0, w_mtc0, w_eret;
    logic       w_alu_class;

    // Per-instruction ALU/immediate controls, reused across EXE, MEM and WB
    logic [1:0] w_ins_aluop;
    logic       w_ins_alusrc;
    logic       w_ins_extop;

    // Raw (pre-reset-gating) outputs
    logic       w_pcwr, w_irwr, w_regwr, w_memwr, w_prwe;
    logic       w_cp0we, w_epcwr, w_exlset, w_exlclr;
    logic [1:0] w_regdst;
    logic       w_alusrc;
    logic       w_extop;
    logic [1:0] w_aluop;
    logic [2:0] w_memtoreg;
    logic [2:0] w_npcop;

    assign w_rtype = (bus.op == OP_RTYPE);
    assign w_cop0  = (bus.op == OP_COP0);
    assign w_addu  = w_rtype && (bus.funct == FN_ADDU);
    assign w_subu  = w_rtype && (bus.funct == FN_SUBU);
    assign w_jr    = w_rtype && (bus.funct == FN_JR);
    assign w_jalr  = w_rtype && (bus.funct == FN_JALR);
    assign w_ori   = (bus.op == OP_ORI);
    assign w_lui   = (bus.op == OP_LUI);
    assign w_lw    = (bus.op == OP_LW);
    assign w_sw    = (bus.op == OP_SW);
    assign w_beq   = (bus.op == OP_BEQ);
    assign w_j     = (bus.op == OP_J);
    assign w_jal   = (bus.op == OP_JAL);
    assign w_mfc0  = w_cop0 && (bus.rs == RS_MFC0);
    assign w_mtc0  = w_cop0 && (bus.rs == RS_MTC0);
    assign w_eret  = w_cop0 && (bus.rs == RS_ERET);

    // Instructions that need EXE (all supported ones except the DCD-completing jumps/eret)
    assign w_alu_class = w_addu | w_subu | w_ori | w_lui | w_lw | w_sw
                       | w_beq | w_mfc0 | w_mtc0;

    // Boundary decision uses exl as sampled now, i.e. before any exlclr takes effect
    assign w_end_next = (bus.intreq && !bus.exl) ? S_INT : S_FETCH;

    // ALU/immediate controls of the current instruction, held stable through MEM/WB
    always_comb begin
        w_ins_aluop  = ALU_ADD;
        w_ins_alusrc = 1'b0;
        w_ins_extop  = 1'b0;
        if (w_subu) begin
            w_ins_aluop = ALU_SUB;
        end else if (w_ori) begin
            w_ins_aluop  = ALU_OR;
            w_ins_alusrc = 1'b1;
        end else if (w_lui) begin
            w_ins_aluop  = ALU_LUI;
            w_ins_alusrc = 1'b1;
        end else if (w_lw || w_sw) begin
            w_ins_aluop  = ALU_ADD;
            w_ins_alusrc = 1'b1;
            w_ins_extop  = 1'b1;
        end
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs decoded from state and IR fields
    always_comb begin
        w_next     = S_FETCH;
        w_pcwr     = 1'b0;
        w_irwr     = 1'b0;
        w_regwr    = 1'b0;
        w_memwr    = 1'b0;
        w_prwe     = 1'b0;
        w_cp0we    = 1'b0;
        w_epcwr    = 1'b0;
        w_exlset   = 1'b0;
        w_exlclr   = 1'b0;
        w_regdst   = RD_RT;
        w_alusrc   = 1'b0;
        w_extop    = 1'b0;
        w_aluop    = ALU_ADD;
        w_memtoreg = M2R_ALU;
        w_npcop    = NPC_PC4;

        case (r_state)
            S_FETCH: begin
                w_irwr  = 1'b1;
                w_pcwr  = 1'b1;
                w_npcop = NPC_PC4;
                w_next  = S_DCD;
            end

            S_DCD: begin
                if (w_j || w_jal) begin
                    w_pcwr  = 1'b1;
                    w_npcop = NPC_JMP;
                    if (w_jal) begin
                        w_regwr    = 1'b1;
                        w_regdst   = RD_R31;
                        w_memtoreg = M2R_PC4;
                    end
                    w_next = w_end_next;
                end else if (w_jr || w_jalr) begin
                    w_pcwr  = 1'b1;
                    w_npcop = NPC_JR;
                    if (w_jalr) begin
                        w_regwr    = 1'b1;
                        w_regdst   = RD_RD;
                        w_memtoreg = M2R_PC4;
                    end
                    w_next = w_end_next;
                end else if (w_eret) begin
                    w_pcwr   = 1'b1;
                    w_npcop  = NPC_EPC;
                    w_exlclr = 1'b1;
                    w_next   = w_end_next;
                end else if (w_alu_class) begin
                    w_next = S_EXE;
                end else begin
                    // Unsupported encoding: behaves as a NOP
                    w_next = S_FETCH;
                end
            end

            S_EXE: begin
                w_aluop  = w_ins_aluop;
                w_alusrc = w_ins_alusrc;
                w_extop  = w_ins_extop;
                if (w_beq) begin
                    w_aluop  = ALU_SUB;
                    w_alusrc = 1'b0;
                    w_pcwr   = bus.zero;
                    w_npcop  = NPC_BR;
                    w_next   = w_end_next;
                end else if (w_mtc0) begin
                    w_cp0we = 1'b1;
                    w_next  = w_end_next;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end

            S_MEM: begin
                w_aluop  = w_ins_aluop;
                w_alusrc = w_ins_alusrc;
                w_extop  = w_ins_extop;
                if (w_sw) begin
                    w_memwr = !bus.hitdev;
                    w_prwe  = bus.hitdev;
                    w_next  = w_end_next;
                end else if (w_lw) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_FETCH;
                end
            end

            S_WB: begin
                w_aluop  = w_ins_aluop;
                w_alusrc = w_ins_alusrc;
                w_extop  = w_ins_extop;
                w_regwr  = 1'b1;
                w_regdst = (w_addu || w_subu) ? RD_RD : RD_RT;
                if (w_lw) begin
                    w_memtoreg = bus.hitdev ? M2R_PRRD : M2R_DMEM;
                end else if (w_mfc0) begin
                    w_memtoreg = M2R_CP0;
                end else begin
                    w_memtoreg = M2R_ALU;
                end
                w_next = w_end_next;
            end

            S_INT: begin
                w_epcwr  = 1'b1;
                w_exlset = 1'b1;
                w_pcwr   = 1'b1;
                w_npcop  = NPC_HDL;
                w_next   = S_FETCH;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Write enables are suppressed during reset so an aborted instruction cannot commit
    assign bus.pcwr     = w_pcwr   && !reset;
    assign bus.irwr     = w_irwr   && !reset;
    assign bus.regwr    = w_regwr  && !reset;
    assign bus.memwr    = w_memwr  && !reset;
    assign bus.prwe     = w_prwe   && !reset;
    assign bus.cp0we    = w_cp0we  && !reset;
    assign bus.epcwr    = w_epcwr  && !reset;
    assign bus.exlset   = w_exlset && !reset;
    assign bus.exlclr   = w_exlclr && !reset;
    assign bus.regdst   = w_regdst;
    assign bus.alusrc   = w_alusrc;
    assign bus.extop    = w_extop;
    assign bus.aluop    = w_aluop;
    assign bus.memtoreg = w_memtoreg;
    assign bus.npcop    = w_npcop;
    assign bus.state    = r_state;

endmodule
